// File: rtl/wb_commit_queue_pkg.sv
// ---------------------------------------------------------------------------
// wb_commit_queue_pkg
// Shared types and constants for the in-order writeback commit queue.
//   WB_DEPTH  : default number of queue entries (power of two, >= 4)
//   GPR_ZERO  : architectural zero register; writes to it are dropped
//   wb_entry  : one completed result waiting to be written back
// ---------------------------------------------------------------------------
package wb_commit_queue_pkg;

   localparam int WB_DEPTH = 8;

   localparam logic [4:0] GPR_ZERO = 5'd0;

   typedef struct packed {
      logic [4:0]  addr;
      logic        we;
      logic [31:0] data;
      logic        hi_we;
      logic [31:0] hi;
      logic        lo_we;
      logic [31:0] lo;
   } wb_entry;

endpackage

// File: rtl/wb_commit_queue_hilo_merge.sv
// ---------------------------------------------------------------------------
// wb_hilo_merge
// Collapses two same-cycle HI (or LO) updates onto the single HI/LO write
// port. The younger entry's value wins because it is architecturally later.
//   older_we,   older_data   : update carried by the older retiring entry
//   younger_we, younger_data : update carried by the younger retiring entry
//   merged_we,  merged_data  : value presented to the register file
// ---------------------------------------------------------------------------
module wb_hilo_merge (
   input  logic        older_we,
   input  logic [31:0] older_data,
   input  logic        younger_we,
   input  logic [31:0] younger_data,
   output logic        merged_we,
   output logic [31:0] merged_data
);

   // Younger beats older; data stays at zero when neither writes so the
   // port is quiet while idle.
   always_comb begin
      merged_we   = older_we | younger_we;
      merged_data = '0;
      if (younger_we) begin
         merged_data = younger_data;
      end else if (older_we) begin
         merged_data = older_data;
      end
   end

endmodule

// File: rtl/wb_commit_queue.sv
// ---------------------------------------------------------------------------
// wb_commit_queue
// In-order writeback buffer between the dual-issue execute stage and the
// register file. Up to two results are accepted per cycle into a circular
// FIFO and up to two retire per cycle, oldest first.
//   clk, rst_            : clock, asynchronous active-high reset
//   in0_* / in1_*        : older / younger completed result (valid, GPR
//                          addr/we/data, HI we/data, LO we/data)
//   in_ready             : at least two free entries
//   commit_stall         : hold all retirement this cycle
//   write_addr0/1_*      : GPR write ports (0 = older, 1 = younger)
//   write_hilo_*         : merged HI and LO write port
//   count                : occupied entries
// ---------------------------------------------------------------------------
module wb_commit_queue
   import wb_commit_queue_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             in0_valid,
   input  logic [4:0]       in0_addr,
   input  logic             in0_we,
   input  logic [31:0]      in0_data,
   input  logic             in0_hi_we,
   input  logic [31:0]      in0_hi_data,
   input  logic             in0_lo_we,
   input  logic [31:0]      in0_lo_data,
   input  logic             in1_valid,
   input  logic [4:0]       in1_addr,
   input  logic             in1_we,
   input  logic [31:0]      in1_data,
   input  logic             in1_hi_we,
   input  logic [31:0]      in1_hi_data,
   input  logic             in1_lo_we,
   input  logic [31:0]      in1_lo_data,
   output logic             in_ready,
   input  logic             commit_stall,
   output logic [4:0]       write_addr0,
   output logic             write_addr0_valid,
   output logic [31:0]      write_data0,
   output logic [4:0]       write_addr1,
   output logic             write_addr1_valid,
   output logic [31:0]      write_data1,
   output logic [31:0]      write_hilo_hi_data,
   output logic             write_hilo_hi_data_valid,
   output logic [31:0]      write_hilo_lo_data,
   output logic             write_hilo_lo_data_valid,
   output logic [PTR_W:0]   count
);

   localparam logic [PTR_W:0] READY_LIMIT = (PTR_W+1)'(DEPTH - 2);

   wb_entry            entries [DEPTH];
   logic [DEPTH-1:0]   entry_valid;
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;
   logic [PTR_W-1:0]   head_p1;
   logic [PTR_W-1:0]   tail_p1;
   logic [PTR_W-1:0]   push1_idx;
   wb_entry            in0_entry;
   wb_entry            in1_entry;
   wb_entry            older;
   wb_entry            younger;
   logic               push0;
   logic               push1;
   logic [1:0]         accept_num;
   logic               retire_en;
   logic               port1_present;
   logic [1:0]         retire_num;

   assign in0_entry = '{addr: in0_addr, we: in0_we, data: in0_data,
                        hi_we: in0_hi_we, hi: in0_hi_data,
                        lo_we: in0_lo_we, lo: in0_lo_data};
   assign in1_entry = '{addr: in1_addr, we: in1_we, data: in1_data,
                        hi_we: in1_hi_we, hi: in1_hi_data,
                        lo_we: in1_lo_we, lo: in1_lo_data};

   // Pointer arithmetic wraps for free because DEPTH is a power of two.
   assign head_p1 = head + PTR_W'(1);
   assign tail_p1 = tail + PTR_W'(1);

   // Readiness looks only at the pre-edge occupancy so upstream sees a
   // stable answer regardless of what retires this cycle.
   assign in_ready   = (count <= READY_LIMIT);
   assign push0      = in_ready & in0_valid;
   assign push1      = in_ready & in1_valid;
   assign push1_idx  = in0_valid ? tail_p1 : tail;
   assign accept_num = {1'b0, push0} + {1'b0, push1};

   // Retirement is a pure function of the head entries; port 1 only
   // carries an entry when two are queued.
   assign older         = entries[head];
   assign younger       = entries[head_p1];
   assign retire_en     = ~commit_stall & (count != '0);
   assign port1_present = retire_en & (count >= (PTR_W+1)'(2));
   assign retire_num    = {1'b0, retire_en} + {1'b0, port1_present};

   assign write_addr0       = retire_en ? older.addr : '0;
   assign write_data0       = retire_en ? older.data : '0;
   assign write_addr0_valid = retire_en & entry_valid[head] & older.we &
                              (older.addr != GPR_ZERO);

   assign write_addr1       = port1_present ? younger.addr : '0;
   assign write_data1       = port1_present ? younger.data : '0;
   assign write_addr1_valid = port1_present & entry_valid[head_p1] & younger.we &
                              (younger.addr != GPR_ZERO);

   wb_hilo_merge hi_merge (
      .older_we     (retire_en & older.hi_we),
      .older_data   (older.hi),
      .younger_we   (port1_present & younger.hi_we),
      .younger_data (younger.hi),
      .merged_we    (write_hilo_hi_data_valid),
      .merged_data  (write_hilo_hi_data)
   );

   wb_hilo_merge lo_merge (
      .older_we     (retire_en & older.lo_we),
      .older_data   (older.lo),
      .younger_we   (port1_present & younger.lo_we),
      .younger_data (younger.lo),
      .merged_we    (write_hilo_lo_data_valid),
      .merged_data  (write_hilo_lo_data)
   );

   // Payload storage carries no reset; occupancy is tracked separately so
   // stale payloads are never observed after a reset.
   always_ff @(posedge clk) begin
      if (push0) begin
         entries[tail] <= in0_entry;
      end
      if (push1) begin
         entries[push1_idx] <= in1_entry;
      end
   end

   // Queue bookkeeping. Enqueue slots are always free and retire slots are
   // always occupied, so the valid-bit clears and sets never collide.
   always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         entry_valid <= '0;
      end else begin
         if (retire_en) begin
            entry_valid[head] <= 1'b0;
         end
         if (port1_present) begin
            entry_valid[head_p1] <= 1'b0;
         end
         if (push0) begin
            entry_valid[tail] <= 1'b1;
         end
         if (push1) begin
            entry_valid[push1_idx] <= 1'b1;
         end
         head  <= head + PTR_W'(retire_num);
         tail  <= tail + PTR_W'(accept_num);
         count <= count + (PTR_W+1)'(accept_num) - (PTR_W+1)'(retire_num);
      end
   end

endmodule

// File: tb/tb_wb_commit_queue.sv
// ---------------------------------------------------------------------------
// tb_wb_commit_queue
// Self-checking bench for wb_commit_queue (DEPTH 8). A queue-based model
// predicts every cycle's outputs; directed vectors and corner sequences
// exercise the documented scenarios, then randomized traffic follows.
// ---------------------------------------------------------------------------
module tb_wb_commit_queue;

   localparam int DEPTH = 8;

   typedef struct packed {
      logic        valid;
      logic [4:0]  addr;
      logic        we;
      logic [31:0] data;
      logic        hi_we;
      logic [31:0] hi;
      logic        lo_we;
      logic [31:0] lo;
   } slot_t;

   typedef struct packed {
      slot_t       in0;
      slot_t       in1;
      logic        v0;
      logic [4:0]  a0;
      logic [31:0] d0;
      logic        v1;
      logic [4:0]  a1;
      logic [31:0] d1;
      logic        hv;
      logic [31:0] hd;
      logic        lv;
      logic [31:0] ld;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_;
   logic        stall;
   slot_t       in0_s;
   slot_t       in1_s;
   logic        in_ready;
   logic [4:0]  write_addr0;
   logic        write_addr0_valid;
   logic [31:0] write_data0;
   logic [4:0]  write_addr1;
   logic        write_addr1_valid;
   logic [31:0] write_data1;
   logic [31:0] hi_data;
   logic        hi_valid;
   logic [31:0] lo_data;
   logic        lo_valid;
   logic [3:0]  count;

   int          check_count = 0;
   int          pass_count  = 0;
   slot_t       model_q[$];
   vec_t        vectors[6];
   slot_t       idle_slot;

   wb_commit_queue #(.DEPTH(DEPTH), .PTR_W(3)) dut (
      .clk                      (clk),
      .rst_                     (rst_),
      .in0_valid                (in0_s.valid),
      .in0_addr                 (in0_s.addr),
      .in0_we                   (in0_s.we),
      .in0_data                 (in0_s.data),
      .in0_hi_we                (in0_s.hi_we),
      .in0_hi_data              (in0_s.hi),
      .in0_lo_we                (in0_s.lo_we),
      .in0_lo_data              (in0_s.lo),
      .in1_valid                (in1_s.valid),
      .in1_addr                 (in1_s.addr),
      .in1_we                   (in1_s.we),
      .in1_data                 (in1_s.data),
      .in1_hi_we                (in1_s.hi_we),
      .in1_hi_data              (in1_s.hi),
      .in1_lo_we                (in1_s.lo_we),
      .in1_lo_data              (in1_s.lo),
      .in_ready                 (in_ready),
      .commit_stall             (stall),
      .write_addr0              (write_addr0),
      .write_addr0_valid        (write_addr0_valid),
      .write_data0              (write_data0),
      .write_addr1              (write_addr1),
      .write_addr1_valid        (write_addr1_valid),
      .write_data1              (write_data1),
      .write_hilo_hi_data       (hi_data),
      .write_hilo_hi_data_valid (hi_valid),
      .write_hilo_lo_data       (lo_data),
      .write_hilo_lo_data_valid (lo_valid),
      .count                    (count)
   );

   always #5 clk = ~clk;

   // Single comparison point; every check funnels through here.
   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s at %0t: actual=%h required=%h", name, $time, actual, expected);
      end
   endtask

   function automatic slot_t mk(input logic [4:0] addr, input logic we, input logic [31:0] data,
                                input logic hi_we, input logic [31:0] hi,
                                input logic lo_we, input logic [31:0] lo);
      slot_t s;
      s = '{valid: 1'b1, addr: addr, we: we, data: data, hi_we: hi_we, hi: hi, lo_we: lo_we, lo: lo};
      return s;
   endfunction

   task automatic applyStimulus(input slot_t s0, input slot_t s1, input logic st);
      in0_s = s0;
      in1_s = s1;
      stall = st;
   endtask

   // Model view: oldest queued result goes to port 0, the next to port 1;
   // a port with nothing to write must show zero address and data only when
   // the whole retirement path is idle.
   task automatic checkOutput();
      bit          idle;
      bit          have_y;
      slot_t       o;
      slot_t       y;
      bit          ev0;
      bit          ev1;
      bit          ehv;
      bit          elv;
      logic [31:0] ehd;
      logic [31:0] eld;
      idle   = stall || model_q.size() == 0;
      have_y = !idle && model_q.size() >= 2;
      o      = idle ? '0 : model_q[0];
      y      = have_y ? model_q[1] : '0;
      ev0    = !idle && o.we && o.addr != 5'd0;
      ev1    = have_y && y.we && y.addr != 5'd0;
      ehv    = (!idle && o.hi_we) || (have_y && y.hi_we);
      ehd    = (have_y && y.hi_we) ? y.hi : ((!idle && o.hi_we) ? o.hi : 32'd0);
      elv    = (!idle && o.lo_we) || (have_y && y.lo_we);
      eld    = (have_y && y.lo_we) ? y.lo : ((!idle && o.lo_we) ? o.lo : 32'd0);
      check("count", 32'(count), 32'(model_q.size()));
      check("in_ready", 32'(in_ready), 32'((DEPTH - model_q.size()) >= 2));
      check("port0_valid", 32'(write_addr0_valid), 32'(ev0));
      check("port1_valid", 32'(write_addr1_valid), 32'(ev1));
      check("hi_valid", 32'(hi_valid), 32'(ehv));
      check("lo_valid", 32'(lo_valid), 32'(elv));
      if (ev0 || idle) begin
         check("port0_addr", 32'(write_addr0), 32'(o.addr));
         check("port0_data", write_data0, o.data);
      end
      if (ev1 || idle) begin
         check("port1_addr", 32'(write_addr1), 32'(y.addr));
         check("port1_data", write_data1, y.data);
      end
      if (ehv || idle) check("hi_data", hi_data, ehd);
      if (elv || idle) check("lo_data", lo_data, eld);
   endtask

   // Advance the model across an edge using the pre-edge inputs.
   task automatic modelUpdate();
      int sz;
      int n;
      bit ready;
      sz    = model_q.size();
      ready = (DEPTH - sz) >= 2;
      n     = (stall || sz == 0) ? 0 : ((sz >= 2) ? 2 : 1);
      repeat (n) void'(model_q.pop_front());
      if (ready) begin
         if (in0_s.valid) model_q.push_back(in0_s);
         if (in1_s.valid) model_q.push_back(in1_s);
      end
   endtask

   // One clock: check mid-cycle, cross the edge, settle just after it.
   task automatic runCycle(input int vec_idx);
      @(negedge clk);
      if (vec_idx >= 0) begin
         check("vec_v0", 32'(write_addr0_valid), 32'(vectors[vec_idx].v0));
         check("vec_v1", 32'(write_addr1_valid), 32'(vectors[vec_idx].v1));
         check("vec_hv", 32'(hi_valid), 32'(vectors[vec_idx].hv));
         check("vec_lv", 32'(lo_valid), 32'(vectors[vec_idx].lv));
         if (vectors[vec_idx].v0) check("vec_p0", {write_addr0, write_data0[26:0]},
                                         {vectors[vec_idx].a0, vectors[vec_idx].d0[26:0]});
         if (vectors[vec_idx].v0) check("vec_d0", write_data0, vectors[vec_idx].d0);
         if (vectors[vec_idx].v1) check("vec_a1", 32'(write_addr1), 32'(vectors[vec_idx].a1));
         if (vectors[vec_idx].v1) check("vec_d1", write_data1, vectors[vec_idx].d1);
         if (vectors[vec_idx].hv) check("vec_hd", hi_data, vectors[vec_idx].hd);
         if (vectors[vec_idx].lv) check("vec_ld", lo_data, vectors[vec_idx].ld);
      end
      checkOutput();
      @(posedge clk);
      modelUpdate();
      #1;
   endtask

   function automatic slot_t randSlot();
      slot_t s;
      s.valid = 1'($urandom_range(0, 1));
      s.addr  = 5'($urandom_range(0, 3));
      s.we    = ($urandom_range(0, 3) != 0);
      s.data  = $urandom;
      s.hi_we = ($urandom_range(0, 2) == 0);
      s.hi    = $urandom;
      s.lo_we = ($urandom_range(0, 2) == 0);
      s.lo    = $urandom;
      return s;
   endfunction

   initial begin
      idle_slot = '0;
      vectors[0] = '{in0: mk(5'd5, 1, 32'hDEAD_BEEF, 0, 0, 0, 0), in1: '0,
                     v0: 1, a0: 5'd5, d0: 32'hDEAD_BEEF, v1: 0, a1: 0, d1: 0,
                     hv: 0, hd: 0, lv: 0, ld: 0};
      vectors[1] = '{in0: mk(5'd3, 1, 32'h11, 0, 0, 0, 0), in1: mk(5'd3, 1, 32'h22, 0, 0, 0, 0),
                     v0: 1, a0: 5'd3, d0: 32'h11, v1: 1, a1: 5'd3, d1: 32'h22,
                     hv: 0, hd: 0, lv: 0, ld: 0};
      vectors[2] = '{in0: mk(5'd0, 0, 0, 1, 32'hAAAA, 0, 0), in1: mk(5'd0, 0, 0, 1, 32'hBBBB, 1, 32'hCCCC),
                     v0: 0, a0: 0, d0: 0, v1: 0, a1: 0, d1: 0,
                     hv: 1, hd: 32'hBBBB, lv: 1, ld: 32'hCCCC};
      vectors[3] = '{in0: mk(5'd0, 1, 32'h1234, 0, 0, 0, 0), in1: '0,
                     v0: 0, a0: 0, d0: 0, v1: 0, a1: 0, d1: 0,
                     hv: 0, hd: 0, lv: 0, ld: 0};
      vectors[4] = '{in0: '0, in1: mk(5'd7, 1, 32'h77, 0, 0, 0, 0),
                     v0: 1, a0: 5'd7, d0: 32'h77, v1: 0, a1: 0, d1: 0,
                     hv: 0, hd: 0, lv: 0, ld: 0};
      vectors[5] = '{in0: mk(5'd9, 0, 0, 0, 0, 1, 32'h5), in1: mk(5'd10, 1, 32'hA0, 1, 32'h6, 0, 0),
                     v0: 0, a0: 0, d0: 0, v1: 1, a1: 5'd10, d1: 32'hA0,
                     hv: 1, hd: 32'h6, lv: 1, ld: 32'h5};

      rst_ = 1'b1;
      applyStimulus(idle_slot, idle_slot, 1'b0);
      #2;
      $display("[TB] reset state");
      checkOutput();
      @(posedge clk);
      #1;
      rst_ = 1'b0;

      $display("[TB] directed vectors");
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vectors[i].in0, vectors[i].in1, 1'b0);
         runCycle(-1);
         applyStimulus(idle_slot, idle_slot, 1'b0);
         runCycle(i);
         runCycle(-1);
      end

      $display("[TB] full queue under stall, then drain");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(mk(5'(2*i+1), 1, 32'h100 + 32'(i), 0, 0, 0, 0),
                       mk(5'(2*i+2), 1, 32'h200 + 32'(i), 0, 0, 0, 0), 1'b1);
         runCycle(-1);
      end
      applyStimulus(mk(5'd20, 1, 32'hBAD0, 0, 0, 0, 0), mk(5'd21, 1, 32'hBAD1, 0, 0, 0, 0), 1'b1);
      check("full_count", 32'(count), 32'd8);
      check("full_ready", 32'(in_ready), 32'd0);
      runCycle(-1);
      applyStimulus(idle_slot, idle_slot, 1'b0);
      for (int i = 0; i < 5; i++) runCycle(-1);

      $display("[TB] asynchronous reset with entries queued");
      applyStimulus(mk(5'd4, 1, 32'h44, 1, 32'h4, 0, 0), mk(5'd6, 1, 32'h66, 0, 0, 1, 32'h6), 1'b1);
      runCycle(-1);
      runCycle(-1);
      applyStimulus(mk(5'd8, 1, 32'h88, 0, 0, 0, 0), idle_slot, 1'b1);
      runCycle(-1);
      check("pre_reset_count", 32'(count), 32'd5);
      applyStimulus(idle_slot, idle_slot, 1'b0);
      #2;
      rst_ = 1'b1;
      #1;
      model_q.delete();
      checkOutput();
      @(posedge clk);
      #1;
      rst_ = 1'b0;
      for (int i = 0; i < 3; i++) runCycle(-1);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(randSlot(), randSlot(), ($urandom_range(0, 3) == 0));
         runCycle(-1);
      end
      applyStimulus(idle_slot, idle_slot, 1'b0);
      for (int i = 0; i < 6; i++) runCycle(-1);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
